multi_sqwave_gen: RTL and testbench
===================================

Name: multi_sqwave_gen

Overview:
Multi-channel, parametrised square-wave / PWM generator. Each channel produces a registered waveform with programmable HIGH and LOW lengths, in continuous or one-shot mode. New lengths are held in shadow registers and take effect only at a period boundary, so the output never glitches. The block feeds the clock-enable and timer-output logic around the processor core.

Parameters:
CNT_W, 8, width of each length field and of each channel's phase counter
NUM_CH, 4, number of independent channels

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  NUM_CH  per-channel run enable (level)
oneshot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = continuous; sampled when the channel starts
high_len  input  NUM_CH*CNT_W  HIGH-phase length in cycles; channel i uses bits [i*CNT_W +: CNT_W]
low_len  input  NUM_CH*CNT_W  LOW-phase length in cycles; same packing as high_len
update  input  1  one-cycle strobe; captures all high_len/low_len fields into the shadow registers
wave_out  output  NUM_CH  registered waveform per channel
period_done  output  NUM_CH  one-cycle pulse on the last cycle of each completed period
busy  output  1  OR of all channels in HIGH or LOW state

Behaviour:
- Reset (asynchronous):
  - wave_out=0, period_done=0, busy=0.
  - All counters, active lengths and shadow lengths = 0; pend_valid=0; every channel in IDLE.
- Per-channel state: IDLE, HIGH, LOW, DONE. The counter counts 0..len-1 within the current phase.
- Shadow registers:
  - update=1 loads pend_high/pend_low from the inputs and sets pend_valid.
  - A second update before the shadow is applied overwrites it; the last strobe wins.
- Applying the shadow:
  - In IDLE or DONE, pend is copied to act_high/act_low on the next edge.
  - In HIGH or LOW, pend is copied only at the period boundary, i.e. the edge that ends the last LOW cycle.
  - pend_valid clears when the copy happens.
- Start:
  - IDLE with en=1 moves to HIGH on the next edge, counter=0.
  - wave_out=1 from that edge, giving 1 cycle latency from en.
  - The oneshot value is latched at this point.
- HIGH phase: lasts act_high cycles, with wave_out=1, then moves to LOW with counter=0.
- LOW phase: lasts act_low cycles, with wave_out=0.
  - period_done=1 during the final LOW cycle, in both modes.
  - In the same cycle as period_done, a pending update is applied.
  - After the period: continuous mode returns to HIGH; one-shot mode goes to DONE.
- Zero lengths (the counter must never underflow):
  - act_high=0: the HIGH phase is skipped and the channel goes directly to LOW; wave_out stays 0.
  - act_low=0: the LOW phase is skipped; wave_out stays 1; period_done pulses on the last HIGH cycle.
  - Both 0: the channel stays in IDLE with wave_out=0 and no period_done, even when en=1. It starts on the edge after a nonzero update is applied.
- Period = act_high + act_low cycles, and the counter never wraps.
  - Compare with counter == len-1, computed in CNT_W bits and guarded by len != 0.
  - Maximum period is 2*(2^CNT_W - 1).
- DONE: wave_out=0. Leaving DONE requires en=0, which returns the channel to IDLE; the next en=1 restarts it.
- en=0 in any state: the next edge forces IDLE, counter=0, wave_out=0, and no period_done. Active and shadow lengths are retained.
- Simultaneous events:
  - update and a period boundary in the same cycle: the boundary copies the OLD pend value; the new values are captured into pend and apply at the following boundary.
  - en falling and a boundary in the same cycle: en wins, and no period_done is issued.
- Reset asserted mid-operation: all state clears immediately. Waveforms resume only after reset is released and a fresh update is applied.

Decomposition:
- Package multi_sqwave_pkg:
  - channel state enum (IDLE/HIGH/LOW/DONE)
  - default CNT_W and NUM_CH constants
  - the length-slice helper
- Sub-module sqwave_channel: one channel's FSM, counter, and active/shadow registers.
  - Instantiated NUM_CH times in a generate loop.
  - The top level only slices buses, broadcasts update, and ORs the per-channel busy signals.

Test Plan:
- ch0 high=3 low=2, update, then en[0]=1 -> wave_out[0] = 1,1,1,0,0 repeating, starting 1 cycle after en; period_done[0] on every 5th cycle, coincident with the second 0.
- ch0 running 3/2; update to 1/1 on the 2nd HIGH cycle -> current period finishes 3/2, then 1,0,1,0...; a second update to 4/4 during that period -> 4/4 starts at the following boundary.
- high=0 low=4 -> wave_out constant 0 with period_done every 4 cycles. high=4 low=0 -> constant 1 with done every 4 cycles. Both 0 with en=1 -> output 0, no done, busy=0.
- ch1 oneshot=1, high=2 low=2 -> output 1,1,0,0 then 0 forever; period_done once; busy falls. Toggling en[1] low then high -> exactly one more period.
- CNT_W=8, high=255 low=255 -> period 510 with no counter wrap; en deasserted mid-HIGH -> wave_out=0 next cycle and no period_done.
- Reset pulse mid-HIGH on all 4 channels -> wave_out=0 immediately and busy=0; after release, en=1 with no update -> output stays 0.

Source files
------------

// File: rtl/multi_sqwave_pkg.sv
// Shared types and helpers for the multi-channel square-wave / PWM generator.
package multi_sqwave_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } ch_state_e;

  // LSB position of channel ch's field inside a packed NUM_CH*w bus.
  function automatic int slice_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/multi_sqwave_gen_if.sv
// Control/status bundle of the generator; state_dbg carries each channel's FSM state (2 bits per channel).
interface multi_sqwave_gen_if
  import multi_sqwave_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NUM_CH = DEF_NUM_CH
);
  // No valid/ready pair here: en/oneshot are levels, update is a single-cycle
  // strobe sampled on every clk edge, and all outputs are plain status levels.
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       oneshot;
  logic [NUM_CH*CNT_W-1:0] high_len;
  logic [NUM_CH*CNT_W-1:0] low_len;
  logic                    update;
  logic [NUM_CH-1:0]       wave_out;
  logic [NUM_CH-1:0]       period_done;
  logic                    busy;
  logic [2*NUM_CH-1:0]     state_dbg;

  modport master (
    output en, oneshot, high_len, low_len, update,
    input  wave_out, period_done, busy, state_dbg
  );

  modport slave (
    input  en, oneshot, high_len, low_len, update,
    output wave_out, period_done, busy, state_dbg
  );

endinterface

// File: rtl/sqwave_channel.sv
// One generator channel: phase FSM, phase counter, active lengths and a shadow
// copy that is only applied while idle or at a period boundary.
module sqwave_channel
  import multi_sqwave_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             oneshot,
  input  logic             update,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             wave_out,
  output logic             period_done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_e        state, state_n, restart_state;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_high, act_low, pend_high, pend_low;
  logic [CNT_W-1:0] nxt_high, nxt_low;
  logic             pend_valid, os_q, os_n;
  logic             last_high, last_low, period_end, boundary, apply;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    os_n    = os_q;
    // len-1 is only meaningful when len != 0, so the guard keeps cnt from wrapping.
    last_high  = (act_high != '0) && (cnt == act_high - ONE);
    last_low   = (act_low != '0) && (cnt == act_low - ONE);
    period_end = ((state == ST_HIGH) && last_high && (act_low == '0)) ||
                 ((state == ST_LOW) && last_low);
    boundary   = en && period_end;
    apply      = pend_valid && ((state == ST_IDLE) || (state == ST_DONE) || boundary);
    nxt_high   = apply ? pend_high : act_high;
    nxt_low    = apply ? pend_low  : act_low;
    restart_state = os_q ? ST_DONE :
                    (nxt_high != '0) ? ST_HIGH :
                    (nxt_low != '0)  ? ST_LOW  : ST_IDLE;

    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Wait for a pending shadow to land before starting.
          if (!pend_valid && ((act_high != '0) || (act_low != '0))) begin
            state_n = (act_high != '0) ? ST_HIGH : ST_LOW;
            cnt_n   = '0;
            os_n    = oneshot;
          end
        end
        ST_HIGH: begin
          if (last_high) begin
            cnt_n   = '0;
            state_n = (act_low != '0) ? ST_LOW : restart_state;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        ST_LOW: begin
          if (last_low) begin
            cnt_n   = '0;
            state_n = restart_state;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      os_q       <= 1'b0;
      wave_out   <= 1'b0;
      act_high   <= '0;
      act_low    <= '0;
      pend_high  <= '0;
      pend_low   <= '0;
      pend_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      os_q     <= os_n;
      wave_out <= (state_n == ST_HIGH);
      if (apply) begin
        act_high <= pend_high;
        act_low  <= pend_low;
      end
      // A strobe coinciding with an apply refills the shadow after the old value moved over.
      if (update) begin
        pend_high  <= high_len;
        pend_low   <= low_len;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign period_done = boundary;
  assign busy        = (state == ST_HIGH) || (state == ST_LOW);
  assign state_dbg   = state;

endmodule

// File: rtl/multi_sqwave_gen.sv
// Multi-channel square-wave / PWM generator: slices the length buses per channel,
// broadcasts the update strobe and merges per-channel activity into busy.
module multi_sqwave_gen
  import multi_sqwave_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NUM_CH = DEF_NUM_CH
)(
  input logic              clk,
  input logic              reset,
  multi_sqwave_gen_if.slave bus
);

  logic [NUM_CH-1:0]   ch_wave;
  logic [NUM_CH-1:0]   ch_done;
  logic [NUM_CH-1:0]   ch_busy;
  logic [2*NUM_CH-1:0] ch_state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sqwave_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (bus.en[i]),
      .oneshot     (bus.oneshot[i]),
      .update      (bus.update),
      .high_len    (bus.high_len[slice_lsb(i, CNT_W) +: CNT_W]),
      .low_len     (bus.low_len[slice_lsb(i, CNT_W) +: CNT_W]),
      .wave_out    (ch_wave[i]),
      .period_done (ch_done[i]),
      .busy        (ch_busy[i]),
      .state_dbg   (ch_state[2*i +: 2])
    );
  end

  assign bus.wave_out    = ch_wave;
  assign bus.period_done = ch_done;
  assign bus.busy        = |ch_busy;
  assign bus.state_dbg   = ch_state;

endmodule

// File: tb/tb_multi_sqwave_gen.sv
// Bench for multi_sqwave_gen: hand-written vector table, directed corner sequences
// and random traffic checked against a period-position reference model.
module tb_multi_sqwave_gen;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;
  localparam int W      = 2*NUM_CH + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multi_sqwave_gen_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus();
  multi_sqwave_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each running channel is a position inside its period.
  bit m_run[NUM_CH], m_done[NUM_CH], m_pv[NUM_CH], m_os[NUM_CH];
  int m_pos[NUM_CH], m_ah[NUM_CH], m_al[NUM_CH], m_ph[NUM_CH], m_pl[NUM_CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_pv[i] = 0; m_os[i] = 0;
      m_pos[i] = 0; m_ah[i] = 0; m_al[i] = 0; m_ph[i] = 0; m_pl[i] = 0;
    end
  endtask

  function automatic bit m_bnd(input int i);
    return m_run[i] && bus.en[i] && (m_pos[i] == m_ah[i] + m_al[i] - 1);
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [NUM_CH-1:0] w, d;
    logic b;
    w = '0; d = '0; b = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w[i] = m_run[i] && (m_pos[i] < m_ah[i]);
      d[i] = m_bnd(i);
      b    = b | m_run[i];
    end
    return {b, d, w};
  endfunction

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int per, nper;
      bit bnd, apply;
      per   = m_ah[i] + m_al[i];
      bnd   = m_bnd(i);
      apply = m_pv[i] && (!m_run[i] || bnd);
      nper  = apply ? (m_ph[i] + m_pl[i]) : per;
      if (!bus.en[i]) begin
        m_run[i] = 0; m_done[i] = 0; m_pos[i] = 0;
      end else if (!m_run[i] && !m_done[i]) begin
        if (!m_pv[i] && per > 0) begin
          m_run[i] = 1; m_pos[i] = 0; m_os[i] = bus.oneshot[i];
        end
      end else if (m_run[i]) begin
        if (bnd) begin
          m_pos[i] = 0;
          if (m_os[i]) begin
            m_run[i] = 0; m_done[i] = 1;
          end else if (nper == 0) begin
            m_run[i] = 0;
          end
        end else begin
          m_pos[i]++;
        end
      end
      if (apply) begin
        m_ah[i] = m_ph[i]; m_al[i] = m_pl[i];
      end
      if (bus.update) begin
        m_ph[i] = int'(bus.high_len[i*CNT_W +: CNT_W]);
        m_pl[i] = int'(bus.low_len[i*CNT_W +: CNT_W]);
        m_pv[i] = 1;
      end else if (apply) begin
        m_pv[i] = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    exp_q.push_back(model_out());
    check("model", 32'({bus.busy, bus.period_done, bus.wave_out}), 32'(exp_q.pop_front()));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      advance();
    end
  endtask

  task automatic cap_cycle(output logic [NUM_CH-1:0] w, output logic [NUM_CH-1:0] d, output logic b);
    sample();
    w = bus.wave_out;
    d = bus.period_done;
    b = bus.busy;
    advance();
  endtask

  task automatic set_len(input int ch, input int h, input int l);
    bus.high_len[ch*CNT_W +: CNT_W] = h[CNT_W-1:0];
    bus.low_len[ch*CNT_W +: CNT_W]  = l[CNT_W-1:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.en = '0; bus.oneshot = '0; bus.update = 1'b0;
    bus.high_len = '0; bus.low_len = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_state", 32'({bus.busy, bus.period_done, bus.wave_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    advance();
  endtask

  task automatic load(input int ch, input int h, input int l);
    set_len(ch, h, l);
    bus.update = 1'b1;
    run(1);
    bus.update = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en0;
    logic       upd;
    logic       exp_wave;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [NUM_CH-1:0] w, d;
    logic b;
    logic [16:0] wseq, dseq;
    int cnt_w0, cnt_w1, cnt_d0, cnt_d1, cnt_d2, cnt_w2, last_done;
    logic [7:0] bseq;
    logic any_w;

    // ch0 3/2: {en0, update, wave0, done0, busy}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset();
    set_len(0, 3, 2);
    for (int v = 0; v < 15; v++) begin
      bus.en[0]  = vecs[v].en0;
      bus.update = vecs[v].upd;
      sample();
      check($sformatf("tbl_%0d", v),
            32'({bus.wave_out[0], bus.period_done[0], bus.busy}),
            32'({vecs[v].exp_wave, vecs[v].exp_done, vecs[v].exp_busy}));
      advance();
    end
    bus.update = 1'b0;

    // Mid-period updates: 3/2 finishes, then 1/1 twice, then 4/4.
    do_reset();
    load(0, 3, 2);
    run(1);
    bus.en[0] = 1'b1;
    run(1);
    wseq = '0; dseq = '0;
    for (int k = 0; k < 17; k++) begin
      bus.update = 1'b0;
      if (k == 1) begin set_len(0, 1, 1); bus.update = 1'b1; end
      if (k == 6) begin set_len(0, 4, 4); bus.update = 1'b1; end
      cap_cycle(w, d, b);
      wseq = {wseq[15:0], w[0]};
      dseq = {dseq[15:0], d[0]};
    end
    bus.update = 1'b0;
    check("upd_wave_seq", 32'(wseq), 32'(17'b11100101011110000));
    check("upd_done_seq", 32'(dseq), 32'(17'b00001010100000001));

    // Zero-length phases: ch0 0/4, ch1 4/0, ch2 0/0.
    do_reset();
    set_len(0, 0, 4); set_len(1, 4, 0); set_len(2, 0, 0);
    bus.update = 1'b1;
    run(1);
    bus.update = 1'b0;
    run(1);
    bus.en = 4'b0111;
    run(1);
    cnt_w0 = 0; cnt_w1 = 0; cnt_w2 = 0; cnt_d0 = 0; cnt_d1 = 0; cnt_d2 = 0;
    for (int k = 0; k < 12; k++) begin
      cap_cycle(w, d, b);
      cnt_w0 += int'(w[0]); cnt_w1 += int'(w[1]); cnt_w2 += int'(w[2]);
      cnt_d0 += int'(d[0]); cnt_d1 += int'(d[1]); cnt_d2 += int'(d[2]);
    end
    check("zero_high_wave", 32'(cnt_w0), 32'd0);
    check("zero_high_done", 32'(cnt_d0), 32'd3);
    check("zero_low_wave", 32'(cnt_w1), 32'd12);
    check("zero_low_done", 32'(cnt_d1), 32'd3);
    check("zero_both", 32'(cnt_w2 + cnt_d2), 32'd0);
    bus.en = 4'b0100;
    run(2);
    sample();
    check("zero_both_busy", 32'(bus.busy), 32'd0);
    advance();

    // One-shot on ch1, then a re-arm via en low/high.
    do_reset();
    bus.oneshot[1] = 1'b1;
    load(1, 2, 2);
    run(1);
    for (int rep = 0; rep < 2; rep++) begin
      bus.en[1] = 1'b1;
      run(1);
      wseq = '0; dseq = '0; bseq = '0;
      for (int k = 0; k < 8; k++) begin
        cap_cycle(w, d, b);
        wseq = {wseq[15:0], w[1]};
        dseq = {dseq[15:0], d[1]};
        bseq = {bseq[6:0], b};
      end
      check($sformatf("oneshot_wave_%0d", rep), 32'(wseq[7:0]), 32'(8'b11000000));
      check($sformatf("oneshot_done_%0d", rep), 32'(dseq[7:0]), 32'(8'b00010000));
      check($sformatf("oneshot_busy_%0d", rep), 32'(bseq), 32'(8'b11110000));
      bus.en[1] = 1'b0;
      run(1);
    end

    // Maximum lengths: 255/255, then en dropped mid-HIGH of the second period.
    do_reset();
    load(0, 255, 255);
    run(1);
    bus.en[0] = 1'b1;
    run(1);
    cnt_w0 = 0; cnt_d0 = 0; last_done = -1;
    for (int k = 0; k < 510; k++) begin
      cap_cycle(w, d, b);
      cnt_w0 += int'(w[0]);
      cnt_d0 += int'(d[0]);
      if (d[0]) last_done = k;
    end
    check("max_high_cycles", 32'(cnt_w0), 32'd255);
    check("max_done_count", 32'(cnt_d0), 32'd1);
    check("max_done_pos", 32'(last_done), 32'd509);
    run(100);
    bus.en[0] = 1'b0;
    cnt_d0 = 0;
    cap_cycle(w, d, b);
    cnt_d0 += int'(d[0]);
    cap_cycle(w, d, b);
    cnt_d0 += int'(d[0]);
    check("max_stop_wave", 32'({w[0], b}), 32'd0);
    check("max_stop_done", 32'(cnt_d0), 32'd0);

    // Asynchronous reset in the middle of HIGH on all channels.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_len(i, 3, 2);
    bus.update = 1'b1;
    run(1);
    bus.update = 1'b0;
    run(1);
    bus.en = '1;
    run(2);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out", 32'({bus.busy, bus.period_done, bus.wave_out}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    advance();
    any_w = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cap_cycle(w, d, b);
      any_w = any_w | (|w) | b;
    end
    check("midreset_no_restart", 32'(any_w), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.update = ($urandom_range(0, 5) == 0);
      if (bus.update)
        for (int i = 0; i < NUM_CH; i++)
          set_len(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 11) == 0) begin
          bus.en[i]      = ~bus.en[i];
          bus.oneshot[i] = 1'($urandom_range(0, 1));
        end
      end
      run(1);
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
